dcache: RTL and testbench

DCACHE -- requirements
Module: dcache

---
 rtl/dcache_pkg.sv | 21 ++
 rtl/dcache_ctrl.sv | 71 +++++++
 rtl/dcache.sv | 95 +++++++++
 tb/tb_dcache.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared geometry, FSM encoding and byte-select helper for the 8-line x 4-byte
// direct-mapped write-back data cache.
package dcache_pkg;
   localparam int TAG_W    = 3;
   localparam int INDEX_W  = 3;
   localparam int OFFSET_W = 2;
   localparam int BLOCK_W  = 32;
   localparam int LINES    = 1 << INDEX_W;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      FETCH     = 2'd2,
      UPDATE    = 2'd3
   } state_t;

   function automatic logic [7:0] get_byte(input logic [BLOCK_W-1:0] blk,
                                           input logic [OFFSET_W-1:0] off);
      return blk[{off, 3'b000} +: 8];
   endfunction
endpackage

// File: rtl/dcache_ctrl.sv
// Miss-handling FSM: sequences optional write-back, block fetch and line update.
// Memory strobes are registered so they come straight from flops.
module dcache_ctrl
   import dcache_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   req,
   input  logic   hit,
   input  logic   line_dirty,
   input  logic   mem_busywait,
   output state_t state,
   output logic   mem_read,
   output logic   mem_write,
   output logic   busywait
);
   state_t state_q, state_d;
   logic   mem_read_q, mem_read_d;
   logic   mem_write_q, mem_write_d;

   always_comb begin
      state_d     = state_q;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (req && !hit) begin
               if (line_dirty) begin
                  state_d     = WRITEBACK;
                  mem_write_d = 1'b1;
               end else begin
                  state_d    = FETCH;
                  mem_read_d = 1'b1;
               end
            end
         end
         WRITEBACK: begin
            // Strobe hand-off to the fetch happens on the same edge the write completes.
            if (!mem_busywait) begin
               state_d    = FETCH;
               mem_read_d = 1'b1;
            end else begin
               mem_write_d = 1'b1;
            end
         end
         FETCH: begin
            if (!mem_busywait) state_d = UPDATE;
            else               mem_read_d = 1'b1;
         end
         UPDATE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
      end
   end

   assign state     = state_q;
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign busywait  = (state_q != IDLE) || (req && !hit);
endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache: 8 lines of 4 bytes.
// Storage arrays and hit logic live here; miss sequencing is in dcache_ctrl.
module dcache
   import dcache_pkg::*;
(
   input  logic                CLK,
   input  logic                RESET,
   input  logic                READ,
   input  logic                WRITE,
   input  logic [7:0]          ADDRESS,
   input  logic [7:0]          WRITEDATA,
   output logic [7:0]          READDATA,
   output logic                BUSYWAIT,
   output logic                MEM_READ,
   output logic                MEM_WRITE,
   output logic [5:0]          MEM_ADDRESS,
   output logic [BLOCK_W-1:0]  MEM_WRITEDATA,
   input  logic [BLOCK_W-1:0]  MEM_READDATA,
   input  logic                MEM_BUSYWAIT
);
   logic [TAG_W-1:0]    tag;
   logic [INDEX_W-1:0]  idx;
   logic [OFFSET_W-1:0] off;

   assign tag = ADDRESS[7:5];
   assign idx = ADDRESS[4:2];
   assign off = ADDRESS[1:0];

   logic [BLOCK_W-1:0] data_q [LINES];
   logic [BLOCK_W-1:0] data_d [LINES];
   logic [TAG_W-1:0]   tag_q  [LINES];
   logic [TAG_W-1:0]   tag_d  [LINES];
   logic [LINES-1:0]   valid_q, valid_d;
   logic [LINES-1:0]   dirty_q, dirty_d;
   logic [BLOCK_W-1:0] fetch_q, fetch_d;

   logic   hit;
   logic   req;
   state_t state;

   assign req = READ || WRITE;
   assign hit = valid_q[idx] && (tag_q[idx] == tag);

   dcache_ctrl u_ctrl (
      .clk          (CLK),
      .rst          (RESET),
      .req          (req),
      .hit          (hit),
      .line_dirty   (dirty_q[idx]),
      .mem_busywait (MEM_BUSYWAIT),
      .state        (state),
      .mem_read     (MEM_READ),
      .mem_write    (MEM_WRITE),
      .busywait     (BUSYWAIT)
   );

   assign MEM_ADDRESS   = (state == WRITEBACK) ? {tag_q[idx], idx} : ADDRESS[7:2];
   assign MEM_WRITEDATA = data_q[idx];
   assign READDATA      = get_byte(data_q[idx], off);

   always_comb begin
      data_d  = data_q;
      tag_d   = tag_q;
      valid_d = valid_q;
      dirty_d = dirty_q;
      fetch_d = fetch_q;
      if (state == FETCH && !MEM_BUSYWAIT) fetch_d = MEM_READDATA;
      if (state == UPDATE) begin
         data_d[idx]  = fetch_q;
         tag_d[idx]   = tag;
         valid_d[idx] = 1'b1;
         dirty_d[idx] = 1'b0;
      end else if (state == IDLE && WRITE && hit) begin
         // WRITE wins when READ is also asserted; a read never modifies the line.
         data_d[idx][{off, 3'b000} +: 8] = WRITEDATA;
         dirty_d[idx] = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   always_ff @(posedge CLK) begin
      data_q  <= data_d;
      tag_q   <= tag_d;
      fetch_q <= fetch_d;
   end
endmodule

// File: tb/tb_dcache.sv
// Randomized scoreboard bench for dcache with a behavioural cache/memory model.
module tb_dcache;
   logic        CLK;
   logic        RESET;
   logic        READ, WRITE;
   logic [7:0]  ADDRESS, WRITEDATA, READDATA;
   logic        BUSYWAIT, MEM_READ, MEM_WRITE;
   logic [5:0]  MEM_ADDRESS;
   logic [31:0] MEM_WRITEDATA, MEM_READDATA;
   logic        MEM_BUSYWAIT;

   dcache dut (
      .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
      .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
      .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
      .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
      .MEM_BUSYWAIT(MEM_BUSYWAIT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct packed {
      logic        wr;
      logic [5:0]  addr;
      logic [31:0] data;
   } mtx_t;

   int checks;
   int failures;
   int mem_lat;

   logic [31:0] dm [64];
   logic [31:0] em [64];
   bit          m_valid [8];
   bit          m_dirty [8];
   logic [2:0]  m_tag   [8];
   logic [7:0]  m_data  [8][4];
   logic [7:0]  exp_rd_q [$];
   mtx_t        exp_mem_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic bit model_hit(input logic [7:0] a);
      return m_valid[a[4:2]] && (m_tag[a[4:2]] == a[7:5]);
   endfunction

   function automatic logic [31:0] model_line(input int i);
      return {m_data[i][3], m_data[i][2], m_data[i][1], m_data[i][0]};
   endfunction

   // Cache semantics: evict-if-dirty, allocate, then apply the CPU access.
   task automatic model_apply(input bit rd, input bit wr, input logic [7:0] a,
                              input logic [7:0] wd, input bit withdraw, output int stall);
      int          i;
      logic [31:0] blk;
      mtx_t        t;
      i = int'(a[4:2]);
      stall = 0;
      if (!model_hit(a)) begin
         if (m_valid[i] && m_dirty[i]) begin
            blk = model_line(i);
            t.wr = 1'b1; t.addr = {m_tag[i], a[4:2]}; t.data = blk;
            exp_mem_q.push_back(t);
            em[{m_tag[i], a[4:2]}] = blk;
            stall += mem_lat;
         end
         t.wr = 1'b0; t.addr = a[7:2]; t.data = '0;
         exp_mem_q.push_back(t);
         blk = em[a[7:2]];
         for (int b = 0; b < 4; b++) m_data[i][b] = blk[8*b +: 8];
         m_tag[i]   = a[7:5];
         m_valid[i] = 1'b1;
         m_dirty[i] = 1'b0;
         stall += mem_lat + 2;
      end
      if (!withdraw) begin
         if (wr) begin
            m_data[i][a[1:0]] = wd;
            m_dirty[i] = 1'b1;
         end else if (rd) begin
            exp_rd_q.push_back(m_data[i][a[1:0]]);
         end
      end
   endtask

   task automatic do_op(input bit rd, input bit wr, input logic [7:0] a,
                        input logic [7:0] wd, input bit withdraw);
      int es;
      int stall;
      model_apply(rd, wr, a, wd, withdraw, es);
      @(negedge CLK);
      READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
      if (withdraw) begin
         @(negedge CLK);
         READ = 1'b0; WRITE = 1'b0;
      end
      #1;
      stall = 0;
      while (BUSYWAIT && stall < 200) begin
         @(negedge CLK);
         #1;
         stall++;
      end
      if (withdraw) check("withdraw_settle", BUSYWAIT, 1'b0);
      else          check("stall_cycles", stall, es);
   endtask

   task automatic gap();
      @(negedge CLK);
      READ = 1'b0; WRITE = 1'b0;
      #1;
      check("idle_busywait", BUSYWAIT, 1'b0);
   endtask

   // Memory responder: busy for mem_lat-1 cycles after a strobe, then completes.
   initial begin : responder
      int   cnt;
      mtx_t e;
      cnt = 0;
      MEM_BUSYWAIT = 1'b0;
      MEM_READDATA = '0;
      forever begin
         @(negedge CLK);
         if (MEM_READ || MEM_WRITE) begin
            cnt++;
            if (cnt >= mem_lat) begin
               MEM_BUSYWAIT = 1'b0;
               cnt = 0;
               if (exp_mem_q.size() == 0) begin
                  check("mem_unexpected", {MEM_WRITE, MEM_ADDRESS}, 7'h7F);
               end else begin
                  e = exp_mem_q.pop_front();
                  check("mem_kind", MEM_WRITE, e.wr);
                  check("mem_addr", MEM_ADDRESS, e.addr);
                  if (e.wr) check("mem_wdata", MEM_WRITEDATA, e.data);
               end
               if (MEM_WRITE) dm[MEM_ADDRESS] = MEM_WRITEDATA;
               else           MEM_READDATA = dm[MEM_ADDRESS];
            end else begin
               MEM_BUSYWAIT = 1'b1;
            end
         end else begin
            cnt = 0;
            MEM_BUSYWAIT = 1'b0;
         end
      end
   end

   // Read-data monitor and per-cycle strobe exclusivity.
   initial begin : monitor
      logic [7:0] e;
      forever begin
         @(negedge CLK);
         #1;
         if (MEM_READ || MEM_WRITE) check("strobe_exclusive", MEM_READ && MEM_WRITE, 1'b0);
         if (READ && !WRITE && !BUSYWAIT && !RESET) begin
            if (exp_rd_q.size() == 0) begin
               check("read_unexpected", READDATA, 8'hxx);
            end else begin
               e = exp_rd_q.pop_front();
               check("readdata", READDATA, e);
            end
         end
      end
   end

   initial begin : stim
      logic [7:0] a;
      int         op;
      bit         wd_en;
      int         n;
      checks = 0; failures = 0; mem_lat = 5;
      RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
      for (int i = 0; i < 64; i++) begin
         dm[i] = $urandom;
         em[i] = dm[i];
      end
      dm[5] = 32'hDDCCBBAA;
      em[5] = 32'hDDCCBBAA;
      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0;
         for (int b = 0; b < 4; b++) m_data[i][b] = '0;
      end
      repeat (3) @(negedge CLK);
      RESET = 1'b0;
      #1;
      check("reset_busywait", BUSYWAIT, 1'b0);
      check("reset_mem_read", MEM_READ, 1'b0);
      check("reset_mem_write", MEM_WRITE, 1'b0);

      // Directed: clean miss, hit, write hit, dirty eviction, read+write collision.
      do_op(1, 0, 8'h14, 8'h00, 0);
      do_op(1, 0, 8'h15, 8'h00, 0);
      do_op(0, 1, 8'h16, 8'h5A, 0);
      do_op(1, 0, 8'hB4, 8'h00, 0);
      check("wb_block", dm[5], 32'hDD5ABBAA);
      do_op(1, 1, 8'h14, 8'h77, 0);
      do_op(1, 0, 8'h14, 8'h00, 0);
      gap();

      // Reset in the middle of a fetch.
      a = model_hit(8'h60) ? 8'h80 : 8'h60;
      if (m_valid[a[4:2]] && m_dirty[a[4:2]]) begin
         exp_mem_q.push_back(mtx_t'{1'b1, {m_tag[a[4:2]], a[4:2]}, model_line(int'(a[4:2]))});
         em[{m_tag[a[4:2]], a[4:2]}] = model_line(int'(a[4:2]));
      end
      @(negedge CLK);
      READ = 1'b1; WRITE = 1'b0; ADDRESS = a;
      n = 0;
      #1;
      while (!MEM_READ && n < 100) begin
         @(negedge CLK);
         #1;
         n++;
      end
      check("fetch_started", MEM_READ, 1'b1);
      @(posedge CLK);
      #2;
      RESET = 1'b1;
      #1;
      check("rst_drops_mem_read", MEM_READ, 1'b0);
      check("rst_mem_write", MEM_WRITE, 1'b0);
      READ = 1'b0;
      #1;
      check("rst_idle_busywait", BUSYWAIT, 1'b0);
      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      @(negedge CLK);
      RESET = 1'b0;
      do_op(1, 0, a, 8'h00, 0);

      // Random mix of reads, writes, collisions and withdrawn misses.
      for (int k = 0; k < 300; k++) begin
         a = 8'($urandom);
         if ($urandom_range(0, 1) == 1) a[7:5] = 3'($urandom_range(0, 1));
         mem_lat = $urandom_range(1, 4);
         op = $urandom_range(0, 3);
         wd_en = !model_hit(a) && ($urandom_range(0, 4) == 0);
         do_op(op <= 1 || op == 3, op >= 2, a, 8'($urandom), wd_en);
         if ($urandom_range(0, 3) == 0) gap();
      end
      gap();
      repeat (3) @(negedge CLK);
      check("rd_queue_drained", exp_rd_q.size(), 0);
      check("mem_queue_drained", exp_mem_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
